// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump reader: address width,
// the zero-register index and the FSM state encodings.
package reg_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_LOAD = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump.sv
// Debug reader that walks FIRST_REG..LAST_REG on one register-file read port
// and streams each sampled value with its index over a valid/ready handshake.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter logic [REG_ADDR_W-1:0] FIRST_REG = 5'd0,
  parameter logic [REG_ADDR_W-1:0] LAST_REG  = 5'd31
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic [REG_ADDR_W-1:0] A,
  input  logic [31:0]           RS,
  output logic [31:0]           OUT_DATA,
  output logic [REG_ADDR_W-1:0] OUT_IDX,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY,
  output logic                  DONE
);

  dump_state_e state;
  dump_state_e next_state;
  logic        handshake;

  assign handshake = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= DUMP_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    DONE       = 1'b0;
    case (state)
      DUMP_IDLE: begin
        if (START) begin
          next_state = DUMP_LOAD;
        end
      end
      DUMP_LOAD: begin
        next_state = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (handshake) begin
          next_state = (A == LAST_REG) ? DUMP_FIN : DUMP_LOAD;
        end
      end
      DUMP_FIN: begin
        DONE       = 1'b1;
        next_state = DUMP_IDLE;
      end
      default: begin
        next_state = DUMP_IDLE;
      end
    endcase
  end

  // Address walk and output word; the word is frozen through SEND until accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A         <= FIRST_REG;
      OUT_DATA  <= 32'd0;
      OUT_IDX   <= REG_ZERO;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        DUMP_IDLE: begin
          A <= FIRST_REG;
          if (START) begin
            BUSY <= 1'b1;
          end
        end
        DUMP_LOAD: begin
          OUT_DATA  <= RS;
          OUT_IDX   <= A;
          OUT_VALID <= 1'b1;
        end
        DUMP_SEND: begin
          if (handshake) begin
            OUT_VALID <= 1'b0;
            if (A != LAST_REG) begin
              A <= A + 5'd1;
            end
          end
        end
        DUMP_FIN: begin
          BUSY <= 1'b0;
          A    <= FIRST_REG;
        end
        default: begin
          A <= FIRST_REG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: full dumps with stalls, ignored restarts,
// in-flight register writes, asynchronous abort and a single-register window.
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, ready0, start1, ready1;
  logic [4:0]  a0, a1, idx0, idx1;
  logic [31:0] rs0, rs1, data0, data1;
  logic        valid0, valid1, busy0, busy1, done0, done1;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  assign rs0 = (a0 == 5'd0) ? 32'd0 : regs[a0];
  assign rs1 = (a1 == 5'd0) ? 32'd0 : regs[a1];

  reg_dump #(.FIRST_REG(5'd0), .LAST_REG(5'd31)) dut0 (
    .CLK(clk), .RST(rst), .START(start0), .A(a0), .RS(rs0),
    .OUT_DATA(data0), .OUT_IDX(idx0), .OUT_VALID(valid0),
    .OUT_READY(ready0), .BUSY(busy0), .DONE(done0)
  );

  reg_dump #(.FIRST_REG(5'd4), .LAST_REG(5'd4)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .A(a1), .RS(rs1),
    .OUT_DATA(data1), .OUT_IDX(idx1), .OUT_VALID(valid1),
    .OUT_READY(ready1), .BUSY(busy1), .DONE(done1)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [4:0]  gi [$];
  logic [31:0] gd [$];
  logic [31:0] exp_data [32];
  int          ndone, done_cyc, busy_cnt;
  vec_t        spot [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic load_regs();
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | i;
    regs[0]  = 32'd0;
    regs[1]  = 32'h1111_1111;
    regs[5]  = 32'hDEAD_BEEF;
    regs[31] = 32'h0000_001F;
    for (int i = 0; i < 32; i++) exp_data[i] = (i == 0) ? 32'd0 : regs[i];
  endtask

  task automatic chk_words(input string tag);
    chk($sformatf("%s_count", tag), gi.size(), 32);
    for (int i = 0; i < gi.size() && i < 32; i++) begin
      chk($sformatf("%s_idx%0d", tag, i), {27'd0, gi[i]}, i);
      chk($sformatf("%s_data%0d", tag, i), gd[i], exp_data[i]);
    end
  endtask

  // Runs one dump on dut0; each option is a word index or -1 for off.
  task automatic run_dump(input int stall_idx, input int restart_idx,
                          input int wr_idx, input int abort_idx);
    int          cyc;
    bit          stalled = 0, restarted = 0, written = 0;
    logic [31:0] sd;
    logic [4:0]  si;
    gi.delete(); gd.delete();
    ndone = 0; done_cyc = -1; busy_cnt = 0;
    ready0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (busy0) busy_cnt++;
      if (done0) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (abort_idx >= 0 && valid0 && idx0 == abort_idx) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_data", data0, 32'd0);
        chk("abort_idx", {27'd0, idx0}, 32'd0);
        chk("abort_valid", {31'd0, valid0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_a", {27'd0, a0}, 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        return;
      end
      if (stall_idx >= 0 && valid0 && idx0 == stall_idx && !stalled) begin
        stalled = 1; ready0 = 1'b0; sd = data0; si = idx0;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1; cyc++;
          chk($sformatf("stall_valid%0d", k), {31'd0, valid0}, 32'd1);
          chk($sformatf("stall_data%0d", k), data0, sd);
          chk($sformatf("stall_idx%0d", k), {27'd0, idx0}, {27'd0, si});
          chk($sformatf("stall_a%0d", k), {27'd0, a0}, {27'd0, si});
        end
        ready0 = 1'b1;
      end
      if (restart_idx >= 0 && valid0 && idx0 == restart_idx && !restarted) begin
        restarted = 1; start0 = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      if (wr_idx >= 0 && valid0 && idx0 == wr_idx && !written) begin
        written = 1; regs[20] = 32'hCAFE_F00D;
      end
      if (valid0 && ready0) begin
        gi.push_back(idx0); gd.push_back(data0);
      end
      @(posedge clk); #1; cyc++;
    end
    start0 = 1'b0;
    if (done_cyc < 0) chk("dump_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; ready0 = 1'b0; start1 = 1'b0; ready1 = 1'b0;
    load_regs();
    spot[0] = '{0,  32'd0};
    spot[1] = '{1,  32'h1111_1111};
    spot[2] = '{5,  32'hDEAD_BEEF};
    spot[3] = '{31, 32'h0000_001F};
    spot[4] = '{20, 32'hA500_0014};

    #12;
    chk("rst_data", data0, 32'd0);
    chk("rst_idx", {27'd0, idx0}, 32'd0);
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_a0", {27'd0, a0}, 32'd0);
    chk("rst_a1", {27'd0, a1}, 32'd4);
    @(posedge clk); #3 rst = 1'b0;

    // Plain full dump, consumer always ready.
    run_dump(-1, -1, -1, -1);
    chk_words("d1");
    for (int i = 0; i < 5; i++) begin
      if (spot[i].idx < gd.size())
        chk($sformatf("spot_r%0d", spot[i].idx), gd[spot[i].idx], spot[i].data);
      else
        chk($sformatf("spot_r%0d_missing", spot[i].idx), gd.size(), spot[i].idx + 1);
    end
    chk("d1_done_cycle", done_cyc, 65);
    chk("d1_done_count", ndone, 1);
    chk("d1_busy_cycles", busy_cnt, 65);
    chk("d1_busy_after", {31'd0, busy0}, 32'd0);
    chk("d1_a_after", {27'd0, a0}, 32'd0);

    // Stall at idx 3, ignored START at idx 10, write r20 while idx 12 is in SEND.
    run_dump(3, 10, 12, -1);
    exp_data[20] = 32'hCAFE_F00D;
    chk_words("d2");
    chk("d2_done_count", ndone, 1);
    chk("d2_done_cycle", done_cyc, 75);

    // Asynchronous abort at idx 7, then a fresh dump from idx 0.
    run_dump(-1, -1, -1, 7);
    chk("d3_words_before_abort", gi.size(), 7);
    chk("d3_no_done", ndone, 0);
    run_dump(-1, -1, -1, -1);
    chk_words("d4");
    chk("d4_done_cycle", done_cyc, 65);

    // Single-register window on dut1; a START during FIN is ignored.
    ready1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    chk("w1_c1_busy", {31'd0, busy1}, 32'd1);
    chk("w1_c1_a", {27'd0, a1}, 32'd4);
    chk("w1_c1_valid", {31'd0, valid1}, 32'd0);
    @(posedge clk); #1;
    chk("w1_c2_valid", {31'd0, valid1}, 32'd1);
    chk("w1_c2_idx", {27'd0, idx1}, 32'd4);
    chk("w1_c2_data", data1, 32'hA500_0004);
    chk("w1_c2_done", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    chk("w1_c3_done", {31'd0, done1}, 32'd1);
    chk("w1_c3_valid", {31'd0, valid1}, 32'd0);
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    chk("w1_c4_done", {31'd0, done1}, 32'd0);
    chk("w1_c4_busy", {31'd0, busy1}, 32'd0);
    @(posedge clk); #1;
    chk("w1_fin_start_ignored", {31'd0, busy1}, 32'd0);
    chk("w1_c5_valid", {31'd0, valid1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
